muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, operand/result width; legal values 32 and 64.
REQ-002 SHALL have parameter TAG_WIDTH, default 5, width of the sideband tag (destination register index).
REQ-003 SHALL have ports clk (input, 1), the single clock, and rst_n (input, 1); one clock, reset asynchronous and active-low.
REQ-004 SHALL have ports in_valid (input, 1), request valid; in_ready (output, 1), unit can accept.
REQ-005 SHALL have ports operand_a and operand_b (input, DATA_WIDTH each), rs1 and rs2 values.
REQ-006 SHALL have port md_op (input, 3), operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have port word_operation (input, 1), 1 = 32-bit W form.
REQ-008 SHALL have port in_tag (input, TAG_WIDTH), carried to out_tag.
REQ-009 SHALL have port flush (input, 1), synchronous abort of any operation in flight.
REQ-010 SHALL have ports out_valid (output, 1), result valid; out_ready (input, 1), consumer accepts.
REQ-011 SHALL have ports result (output, DATA_WIDTH) and out_tag (output, TAG_WIDTH).

Function
REQ-012 SHALL implement FSM IDLE, CALC, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-013 SHALL accept a request on a rising edge with in_valid & in_ready, registering operands, md_op, word_operation and in_tag.
REQ-014 SHALL set iteration count N = 32 when word_operation = 1 or DATA_WIDTH = 32, else N = DATA_WIDTH.
REQ-015 SHALL, for normal operations, go IDLE -> CALC, do one radix-2 iteration per cycle (shift-add multiply, restoring divide) for N cycles, then go to DONE; out_valid rises exactly N+1 cycles after the accept edge.
REQ-016 SHALL, on divide by zero, bypass CALC (IDLE -> DONE, out_valid one cycle after accept): quotient all ones, remainder = dividend.
REQ-017 SHALL, on signed overflow (DIV/REM with dividend = most-negative, divisor = -1, width per N), bypass CALC: quotient = dividend, remainder = 0.
REQ-018 SHALL return the low N bits of the product for MUL and the high N bits for MULH (signed x signed), MULHSU (signed a x unsigned b) and MULHU (unsigned x unsigned).
REQ-019 SHALL, for signed DIV/REM, divide magnitudes and then fix signs: quotient negative iff operand signs differ; remainder takes the dividend's sign.
REQ-020 SHALL, for word forms, use operand bits [31:0] only and sign-extend the 32-bit result from bit 31 to DATA_WIDTH; word_operation is ignored for md_op 001-011 and when DATA_WIDTH = 32.
REQ-021 SHALL hold result and out_tag stable in DONE until out_valid & out_ready, then go to IDLE on that edge; no new request is accepted in the same cycle.
REQ-022 SHALL, when flush = 1, go to IDLE on the next edge from any state, dropping the operation, with out_valid = 0 and no result delivered; flush outranks in_valid and out_ready in the same cycle.
REQ-023 SHALL ignore operand and md_op changes while in CALC or DONE.

Reset
REQ-024 SHALL, while rst_n = 0, asynchronously force IDLE, iteration counter 0, in_ready = 1, out_valid = 0, result = 0, out_tag = 0.
REQ-025 SHALL, on rst_n assertion mid-operation, abandon the operation with no result, and accept a new request on the first edge after rst_n deasserts.

Verification
REQ-026 SHALL cover: DATA_WIDTH=64, MUL a=7, b=-3 -> result 0xFFFFFFFFFFFFFFEB, out_valid 65 cycles after accept, out_tag equals in_tag.
REQ-027 SHALL cover: MULHU a=b=0xFFFFFFFFFFFFFFFF -> 0xFFFFFFFFFFFFFFFE; MULH same operands -> 0.
REQ-028 SHALL cover: DIV a=-7, b=2 -> -3; REM a=-7, b=2 -> -1; DIVU x/0 -> 0xFFFFFFFFFFFFFFFF, 1 cycle latency; REM x/0 -> x.
REQ-029 SHALL cover: DIV 0x8000000000000000 / -1 -> 0x8000000000000000; word DIVW a=0x80000000, b=0xFFFFFFFF -> 0xFFFFFFFF80000000, REMW -> 0.
REQ-030 SHALL cover: MULW a=0x7FFFFFFF, b=2 -> 0xFFFFFFFFFFFFFFFE, latency 33; out_ready held low 10 cycles -> result and out_tag stable, no accept.
REQ-031 SHALL cover: flush in cycle 20 of CALC -> IDLE next edge, no out_valid; rst_n low mid-CALC -> all outputs at reset values immediately.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative integer multiply/divide unit for RV64M/RV32M-style operations.
// A request is accepted in IDLE. Then one radix-2 step per cycle is done in CALC:
// shift-add for multiplies, restoring division for divides.
// The sign-corrected result is held in DONE until the consumer takes it.
// Divide-by-zero and signed overflow skip CALC and produce their result at once.
module muldiv_unit #(
    parameter int DATA_WIDTH = 64,
    parameter int TAG_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    input  logic [2:0]            md_op,
    input  logic                  word_operation,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic [TAG_WIDTH-1:0]  out_tag
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t state_q, state_d;

    // Extend a 32-bit value to W bits, sign-extending when s is set.
    function automatic logic [W-1:0] ext32(input logic s, input logic [31:0] v);
        logic [W-1:0] r;
        r = '0;
        r[31:0] = v;
        for (int i = 32; i < W; i++) r[i] = s & v[31];
        return r;
    endfunction

    // Request decode: operand widths, signedness, magnitudes and the bypass cases.
    logic         is_div, word_sel, a_signed, b_signed, a_neg, b_neg;
    logic         div_zero, div_ovf, bypass;
    logic [W-1:0] a_x, b_x, a_mag, b_mag, bypass_raw;

    // Datapath registers.
    // For multiply: acc = running product, mcand = shifted multiplicand, shf = multiplier.
    // For divide:   acc = partial remainder, mcand = divisor, shf = dividend/quotient.
    logic [2*W-1:0]       acc_q, acc_d, mcand_q, mcand_d;
    logic [W-1:0]         shf_q, shf_d;
    logic [CW-1:0]        cnt_q;
    logic                 n32_q, word_q, div_q, high_q, rem_op_q, neg_q, rem_neg_q;
    logic [W-1:0]         result_q;
    logic [TAG_WIDTH-1:0] tag_q;
    logic                 last_iter;

    // Combinational decode of the incoming request.
    always_comb begin
        is_div   = md_op[2];
        // The W form exists only for MUL and the divides, and only on a 64-bit unit.
        word_sel = word_operation && (W == 64) && (is_div || md_op[1:0] == 2'b00);
        a_signed = is_div ? !md_op[0] : (md_op[1:0] == 2'b01 || md_op[1:0] == 2'b10);
        b_signed = is_div ? !md_op[0] : (md_op[1:0] == 2'b01);
        a_x      = word_sel ? ext32(a_signed, operand_a[31:0]) : operand_a;
        b_x      = word_sel ? ext32(b_signed, operand_b[31:0]) : operand_b;
        a_neg    = a_signed && a_x[W-1];
        b_neg    = b_signed && b_x[W-1];
        a_mag    = a_neg ? -a_x : a_x;
        b_mag    = b_neg ? -b_x : b_x;
        div_zero = is_div && (b_x == '0);
        div_ovf  = is_div && a_signed && (b_x == '1) &&
                   (a_x == (word_sel ? ext32(1'b1, 32'h8000_0000) : {1'b1, {(W-1){1'b0}}}));
        bypass   = div_zero || div_ovf;
        // md_op[1] selects the remainder among the divide operations.
        if (div_zero) bypass_raw = md_op[1] ? operand_a : '1;
        else          bypass_raw = md_op[1] ? '0 : operand_a;
    end

    // One iteration step, plus the final sign fix that is captured on the last step.
    logic [W:0]     rem_sh;
    logic [W-1:0]   rem_diff, quo_fix, rem_fix, calc_raw;
    logic [2*W-1:0] prod_fix;
    logic           ge;
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        shf_d    = shf_q;
        rem_sh   = {acc_q[W-1:0], shf_q[W-1]};
        ge       = rem_sh >= {1'b0, mcand_q[W-1:0]};
        rem_diff = rem_sh[W-1:0] - mcand_q[W-1:0];
        if (div_q) begin
            acc_d = {{W{1'b0}}, (ge ? rem_diff : rem_sh[W-1:0])};
            shf_d = {shf_q[W-2:0], ge};
        end else begin
            if (shf_q[0]) acc_d = acc_q + mcand_q;
            mcand_d = mcand_q << 1;
            shf_d   = shf_q >> 1;
        end
        prod_fix = neg_q ? -acc_d : acc_d;
        quo_fix  = neg_q ? -shf_d : shf_d;
        rem_fix  = rem_neg_q ? -acc_d[W-1:0] : acc_d[W-1:0];
        if (div_q) calc_raw = rem_op_q ? rem_fix : quo_fix;
        else       calc_raw = high_q ? prod_fix[2*W-1:W] : prod_fix[W-1:0];
    end

    assign last_iter = (cnt_q == (n32_q ? CW'(31) : CW'(W - 1)));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state and handshake outputs; flush overrides every other transition.
    always_comb begin
        state_d   = state_q;
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        case (state_q)
            IDLE:    if (in_valid) state_d = bypass ? DONE : CALC;
            CALC:    if (last_iter) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    // Datapath: load on accept, iterate in CALC, capture the result on entry to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            mcand_q   <= '0;
            shf_q     <= '0;
            cnt_q     <= '0;
            n32_q     <= 1'b0;
            word_q    <= 1'b0;
            div_q     <= 1'b0;
            high_q    <= 1'b0;
            rem_op_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            result_q  <= '0;
            tag_q     <= '0;
        end else if (state_q == IDLE && in_valid && !flush) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            n32_q     <= word_sel || (W == 32);
            word_q    <= word_sel;
            div_q     <= is_div;
            high_q    <= (md_op[1:0] != 2'b00);
            rem_op_q  <= md_op[1];
            neg_q     <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            tag_q     <= in_tag;
            if (is_div) begin
                mcand_q <= {{W{1'b0}}, b_mag};
                // Align a 32-bit dividend to the top so 32 steps consume exactly its bits.
                shf_q   <= word_sel ? (a_mag << (W - 32)) : a_mag;
            end else begin
                mcand_q <= {{W{1'b0}}, a_mag};
                shf_q   <= b_mag;
            end
            if (bypass) result_q <= word_sel ? ext32(1'b1, bypass_raw[31:0]) : bypass_raw;
        end else if (state_q == CALC && !flush) begin
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            shf_q   <= shf_d;
            cnt_q   <= cnt_q + CW'(1);
            if (last_iter) result_q <= word_q ? ext32(1'b1, calc_raw[31:0]) : calc_raw;
        end
    end

    assign result  = result_q;
    assign out_tag = tag_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (DATA_WIDTH = 64).
// The driver pushes the expected result, tag and latency of each accepted request
// into a queue. The monitor pops one entry for each result the unit presents.
module tb_muldiv_unit;

    localparam int DW = 64;
    localparam int TW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] operand_a = '0;
    logic [DW-1:0] operand_b = '0;
    logic [2:0]    md_op = '0;
    logic          word_operation = 1'b0;
    logic [TW-1:0] in_tag = '0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] result;
    logic [TW-1:0] out_tag;

    muldiv_unit #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .operand_a(operand_a), .operand_b(operand_b),
        .md_op(md_op), .word_operation(word_operation), .in_tag(in_tag),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] res;
        logic [TW-1:0] tag;
        int            lat;
        int            acc_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    bit   holding = 1'b0;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Monitor: pop on the first cycle of each result, then check it stays stable while held.
    always @(negedge clk) begin
        if (!rst_n) begin
            holding = 1'b0;
        end else if (out_valid) begin
            check("in_ready_low_in_done", 64'(in_ready), 64'd0);
            if (!holding) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out_valid actual=result %h tag %0d required=no result", result, out_tag);
                    cur.res = result;
                    cur.tag = out_tag;
                end else begin
                    cur = sb.pop_front();
                    check("result", result, cur.res);
                    check("out_tag", 64'(out_tag), 64'(cur.tag));
                    check("latency", 64'(cyc - cur.acc_cyc + 1), 64'(cur.lat));
                    $display("result %h tag %0d latency %0d", result, out_tag, cyc - cur.acc_cyc + 1);
                end
                holding = 1'b1;
            end else begin
                check("result_stable", result, cur.res);
                check("out_tag_stable", 64'(out_tag), 64'(cur.tag));
            end
            if (out_ready) holding = 1'b0;
        end else begin
            holding = 1'b0;
        end
    end

    // Issue one request; the caller is at posedge+1, and the task returns at posedge+1 after accept.
    task automatic issue(input logic [2:0] op, input logic w, input logic [63:0] a, input logic [63:0] b,
                         input logic [TW-1:0] tag, input logic [63:0] exp_res, input int exp_lat,
                         input bit push, output int waited);
        exp_t e;
        waited = 0;
        in_valid = 1'b1;
        md_op = op;
        word_operation = w;
        operand_a = a;
        operand_b = b;
        in_tag = tag;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 200) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout actual=in_ready low required=accept within 200 cycles");
                in_valid = 1'b0;
                @(posedge clk);
                #1;
                return;
            end
        end
        @(posedge clk);
        #1;
        $display("issue op %0d word %0d a %h b %h tag %0d accept_cycle %0d", op, w, a, b, tag, cyc);
        e.res = exp_res;
        e.tag = tag;
        e.lat = exp_lat;
        e.acc_cyc = cyc;
        if (push) sb.push_back(e);
        // Scramble request inputs after accept; the unit must ignore them.
        in_valid = 1'b0;
        operand_a = ~a;
        operand_b = a ^ b;
        md_op = ~op;
        word_operation = ~w;
        in_tag = ~tag;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 || !in_ready) begin
            @(negedge clk);
            n++;
            if (n > 300) begin
                checks++;
                errors++;
                $display("FAIL drain_timeout actual=%0d pending required=0", sb.size());
                sb.delete();
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=no finish required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int n;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_result", result, 64'd0);
        check("reset_out_tag", 64'(out_tag), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd3, 64'hFFFF_FFFF_FFFF_FFEB, 65, 1'b1, w);
        issue(3'b011, 1'b0, '1, '1, 5'd4, 64'hFFFF_FFFF_FFFF_FFFE, 65, 1'b1, w);
        issue(3'b001, 1'b0, '1, '1, 5'd5, 64'd0, 65, 1'b1, w);
        issue(3'b010, 1'b0, '1, 64'd2, 5'd6, '1, 65, 1'b1, w);
        issue(3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd7, 64'hFFFF_FFFF_FFFF_FFFD, 65, 1'b1, w);
        issue(3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd8, '1, 65, 1'b1, w);
        issue(3'b101, 1'b0, 64'h1234, 64'd0, 5'd9, '1, 1, 1'b1, w);
        issue(3'b110, 1'b0, 64'hDEAD_BEEF_1234_5678, 64'd0, 5'd10, 64'hDEAD_BEEF_1234_5678, 1, 1'b1, w);
        issue(3'b100, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd11, 64'h8000_0000_0000_0000, 1, 1'b1, w);
        issue(3'b100, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd12, 64'hFFFF_FFFF_8000_0000, 1, 1'b1, w);
        issue(3'b110, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd13, 64'd0, 1, 1'b1, w);
        issue(3'b101, 1'b0, 64'd100, 64'd7, 5'd14, 64'd14, 65, 1'b1, w);
        issue(3'b111, 1'b0, 64'd100, 64'd7, 5'd15, 64'd2, 65, 1'b1, w);
        issue(3'b100, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 5'd16, 64'hFFFF_FFFF_FFFF_FFFD, 33, 1'b1, w);
        issue(3'b101, 1'b1, 64'hAAAA_AAAA_8000_0007, 64'h5555_5555_0000_0010, 5'd17, 64'h0000_0000_0800_0000, 33, 1'b1, w);
        issue(3'b111, 1'b1, 64'hAAAA_AAAA_8000_0007, 64'h5555_5555_0000_0010, 5'd18, 64'd7, 33, 1'b1, w);
        issue(3'b011, 1'b1, 64'h8000_0000_0000_0000, 64'd4, 5'd19, 64'd2, 65, 1'b1, w);
        drain();

        // Back-pressure: hold out_ready low for 10 cycles, with a competing request pending.
        out_ready = 1'b0;
        issue(3'b000, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 5'd20, 64'hFFFF_FFFF_FFFF_FFFE, 33, 1'b1, w);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("hold_out_valid_seen", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        md_op = 3'b000;
        operand_a = 64'd9;
        operand_b = 64'd9;
        in_tag = 5'd30;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        // Flush in cycle 20 of CALC: no result may appear.
        issue(3'b000, 1'b0, 64'd5, 64'd6, 5'd22, 64'd0, 65, 1'b0, w);
        repeat (19) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        repeat (70) @(negedge clk);
        @(posedge clk);
        #1;

        // Asynchronous reset mid-CALC; the outputs clear at once, before any clock edge.
        issue(3'b000, 1'b0, 64'd5, 64'd6, 5'd23, 64'd0, 65, 1'b0, w);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_in_ready", 64'(in_ready), 64'd1);
        check("async_rst_out_valid", 64'(out_valid), 64'd0);
        check("async_rst_result", result, 64'd0);
        check("async_rst_out_tag", 64'(out_tag), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(3'b000, 1'b0, 64'd3, 64'd5, 5'd21, 64'd15, 65, 1'b1, w);
        check("accept_first_edge_after_reset", 64'(w), 64'd0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
